// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU codes,
// datapath mux selects, FSM states and opcode classes.
package ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_J    = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_RTYPE,
        CL_ADDI,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_CMP,
        CL_HALT,
        CL_ILLEGAL
    } opclass_e;

endpackage

// File: rtl/ctrl_opclass.sv
// Opcode classifier: maps the IR opcode to an instruction class and the
// ALU operation used in the EXEC state (zero-extended to ALUCW).
module ctrl_opclass
    import ctrl_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int ALUCW = 3
) (
    input  logic [OPW-1:0]   op,
    output opclass_e         op_class,
    output logic [ALUCW-1:0] aluc
);

    logic       hi_bits;
    logic [3:0] lo;
    logic [2:0] code;

    // Classify the opcode; any set bit above bit 3 makes it illegal.
    always_comb begin
        hi_bits  = |(op >> 4);
        lo       = op[3:0];
        op_class = CL_ILLEGAL;
        code     = ALU_ADD;
        if (!hi_bits) begin
            case (lo)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                    op_class = CL_RTYPE;
                    code     = lo[2:0];
                end
                OP_ADDI: op_class = CL_ADDI;
                OP_LW:   op_class = CL_LOAD;
                OP_SW:   op_class = CL_STORE;
                OP_BEQ, OP_BNE: begin
                    op_class = CL_BRANCH;
                    code     = ALU_SUB;
                end
                OP_J:    op_class = CL_JUMP;
                OP_CMP: begin
                    op_class = CL_CMP;
                    code     = ALU_SUB;
                end
                OP_HALT: op_class = CL_HALT;
                default: op_class = CL_ILLEGAL;
            endcase
        end
        aluc = ALUCW'(code);
    end

endmodule

// File: rtl/multicycle_ctrlunit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with a
// req/ready memory handshake and counts retired instructions.
module multicycle_ctrlunit
    import ctrl_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int ALUCW = 3,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [OPW-1:0]   OP,
    input  logic             ZERO,
    input  logic             MEM_RDY,
    output logic             MEM_REQ,
    output logic             WRITEMEM,
    output logic             IORD,
    output logic             IRWRITE,
    output logic             PCWRITE,
    output logic [1:0]       PCSRC,
    output logic             ALUSRCA,
    output logic [1:0]       ALUSRCB,
    output logic [ALUCW-1:0] ALUC,
    output logic             WRITEREG,
    output logic             MEMTOREG,
    output logic             REGDES,
    output logic             WRFLAG,
    output logic             HALTED,
    output logic             ILLEGAL,
    output logic [CNTW-1:0]  RETIRED
);

    state_e           state_q, state_d;
    logic [CNTW-1:0]  retired_q, retired_d;
    logic             retire;
    opclass_e         op_class;
    logic [ALUCW-1:0] exec_aluc;
    logic             taken;

    ctrl_opclass #(
        .OPW   (OPW),
        .ALUCW (ALUCW)
    ) u_opclass (
        .op       (OP),
        .op_class (op_class),
        .aluc     (exec_aluc)
    );

    // State and retire counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_INIT;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and combinational datapath strobes.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        MEM_REQ  = 1'b0;
        WRITEMEM = 1'b0;
        IORD     = 1'b0;
        IRWRITE  = 1'b0;
        PCWRITE  = 1'b0;
        PCSRC    = PCSRC_ALU;
        ALUSRCA  = 1'b0;
        ALUSRCB  = SRCB_REG;
        ALUC     = '0;
        WRITEREG = 1'b0;
        MEMTOREG = 1'b0;
        REGDES   = 1'b0;
        WRFLAG   = 1'b0;
        HALTED   = 1'b0;
        ILLEGAL  = 1'b0;
        taken    = ZERO;
        if (OP[3:0] == OP_BNE) taken = ~ZERO;

        case (state_q)
            ST_INIT: state_d = ST_FETCH;
            ST_FETCH: begin
                MEM_REQ = 1'b1;
                if (MEM_RDY) begin
                    IRWRITE = 1'b1;
                    PCWRITE = 1'b1;
                    ALUSRCB = SRCB_ONE;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ALUSRCB = SRCB_IMM;
                case (op_class)
                    CL_HALT: state_d = ST_HALT;
                    CL_JUMP: begin
                        PCWRITE = 1'b1;
                        PCSRC   = PCSRC_JUMP;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CL_ILLEGAL: begin
                        ILLEGAL = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                ALUSRCA = 1'b1;
                ALUC    = exec_aluc;
                case (op_class)
                    CL_RTYPE: state_d = ST_WB;
                    CL_ADDI: begin
                        ALUSRCB = SRCB_IMM;
                        state_d = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        ALUSRCB = SRCB_IMM;
                        state_d = ST_MEM;
                    end
                    CL_BRANCH: begin
                        if (taken) begin
                            PCWRITE = 1'b1;
                            PCSRC   = PCSRC_ALUOUT;
                        end
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    CL_CMP: begin
                        WRFLAG  = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                MEM_REQ  = 1'b1;
                IORD     = 1'b1;
                WRITEMEM = (op_class == CL_STORE);
                if (MEM_RDY) begin
                    if (op_class == CL_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                WRITEREG = 1'b1;
                REGDES   = (op_class == CL_RTYPE);
                MEMTOREG = (op_class == CL_LOAD);
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: HALTED = 1'b1;
            default: state_d = ST_INIT;
        endcase

        retired_d = retired_q + CNTW'(retire);
    end

    assign RETIRED = retired_q;

endmodule

// File: doc/multicycle_ctrlunit.md
Name: multicycle_ctrlunit

Overview:
Multi-cycle successor to the single-cycle control unit. It sequences fetch, decode, execute, memory and writeback through an FSM, and drives the same datapath strobes (ALUC, ALUSRCB, WRITEMEM/WRITEREG, MEMTOREG, REGDES, WRFLAG) plus PC, IR and memory-handshake controls. It sits between the instruction register/ALU ZERO flag and the shared datapath. Memory access uses a req/ready handshake, so variable-latency memory is supported.

Parameters:
OPW, 4, opcode width (>=4). Any opcode with a nonzero bit above bit 3 is illegal.
ALUCW, 3, ALU control width (>=3). Codes are zero-extended.
CNTW, 16, width of the retired-instruction counter.

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
OP  in  OPW  opcode from IR; stable from DECODE through retire
ZERO  in  1  ALU zero flag, combinational from the current ALU op
MEM_RDY  in  1  memory completes the access this cycle; ignored when MEM_REQ=0
MEM_REQ  out  1  memory access request
WRITEMEM  out  1  memory write qualifier; valid only with MEM_REQ
IORD  out  1  memory address select: 0=PC, 1=ALUOUT
IRWRITE  out  1  load IR
PCWRITE  out  1  load PC
PCSRC  out  2  PC source: 0=ALU result, 1=ALUOUT (branch target), 2=jump field
ALUSRCA  out  1  ALU A input: 0=PC, 1=reg A
ALUSRCB  out  2  ALU B input: 0=reg B, 1=constant 1, 2=sign-extended immediate
ALUC  out  ALUCW  ALU operation
WRITEREG  out  1  register file write
MEMTOREG  out  1  writeback data: 0=ALUOUT, 1=MDR
REGDES  out  1  destination register: 1=rd, 0=rt
WRFLAG  out  1  write flag register
HALTED  out  1  processor halted
ILLEGAL  out  1  one-cycle pulse on an illegal opcode
RETIRED  out  CNTW  retired-instruction count

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 ADDI, 7 LW, 8 SW, 9 BEQ, A BNE, B J, C CMP, F HALT. D and E are illegal.
- ALUC codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5.
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are combinational from state, OP and ZERO. Any output not listed for a state is 0. RETIRED is registered.
- Reset (RST_N low): state=INIT, RETIRED=0, all outputs 0. INIT lasts one cycle, then FETCH.
- FETCH:
  - MEM_REQ=1, IORD=0, held until MEM_RDY.
  - On the MEM_RDY cycle: IRWRITE=1, PCWRITE=1, PCSRC=0, ALUSRCA=0, ALUSRCB=1, ALUC=ADD; go to DECODE.
  - Without MEM_RDY: stay in FETCH with MEM_REQ held.
- DECODE:
  - ALUSRCA=0, ALUSRCB=2, ALUC=ADD (branch target to ALUOUT).
  - HALT -> HALT.
  - J: PCWRITE=1, PCSRC=2, retire, -> FETCH.
  - Illegal: ILLEGAL=1, retire as NOP, -> FETCH.
  - All others -> EXEC.
- EXEC:
  - R-type (0-5): ALUSRCA=1, ALUSRCB=0, ALUC=op; -> WB.
  - ADDI: ALUSRCA=1, ALUSRCB=2, ADD; -> WB.
  - LW/SW: ALUSRCA=1, ALUSRCB=2, ADD; -> MEM.
  - BEQ/BNE: ALUSRCA=1, ALUSRCB=0, SUB. Taken = BEQ&ZERO | BNE&~ZERO. If taken: PCWRITE=1, PCSRC=1. Retire, -> FETCH.
  - CMP: ALUSRCA=1, ALUSRCB=0, SUB, WRFLAG=1; retire, -> FETCH.
- MEM:
  - MEM_REQ=1, IORD=1, WRITEMEM=1 for SW; held until MEM_RDY.
  - On MEM_RDY: SW retires and goes to FETCH; LW goes to WB.
- WB:
  - WRITEREG=1. REGDES=1 for R-type, 0 for ADDI/LW. MEMTOREG=1 for LW only.
  - Retire, -> FETCH.
- HALT: HALTED=1, all other outputs 0. Stays in HALT until reset. HALT does not retire.
- Latency with zero-wait memory: R-type/ADDI/SW 4 cycles, LW 5, BEQ/BNE/CMP 3, J/illegal 2. Each memory wait state adds 1.
- Retire: RETIRED increments on the rising edge closing the retire cycle. It wraps modulo 2^CNTW.
- Reset asserted mid-access drops MEM_REQ immediately (asynchronous). No partial retire is counted.
- MEM_RDY asserted in a non-memory state has no effect.

Decomposition:
- Package ctrl_pkg: opcode constants, ALUC codes, PCSRC and ALUSRCB encodings, state enum.
- One combinational sub-module, ctrl_opclass: maps OP/OPW to the class {RTYPE, ADDI, LOAD, STORE, BRANCH, JUMP, CMP, HALT, ILLEGAL} and an ALUC value.

Test Plan:
- Reset, then ADD with MEM_RDY tied 1 -> states INIT, FETCH, DECODE, EXEC, WB. WRITEREG=1 and REGDES=1 in cycle 5; RETIRED=1.
- LW with MEM_RDY delayed 2 cycles in both FETCH and MEM -> MEM_REQ held 3 cycles each; IORD=0 then 1; MEMTOREG=1 in WB; total 9 cycles.
- BEQ with ZERO=1, then BEQ with ZERO=0, then BNE with ZERO=0 -> PCWRITE/PCSRC=1 in EXEC for the 1st and 3rd only; RETIRED increments 3.
- Opcode D, then J -> ILLEGAL pulses 1 cycle in DECODE; J gives PCWRITE=1, PCSRC=2; each takes 2 cycles.
- CNTW=2, five ADDs -> RETIRED sequence 1, 2, 3, 0, 1.
- SW stalled in MEM with RST_N pulled low -> MEM_REQ and WRITEMEM drop asynchronously, RETIRED=0, INIT then FETCH. HALT opcode -> HALTED=1 held for 20 cycles.
